// File: rtl/matmul_stream_ctrl.sv
// Word-serial host front end for one matmul core: packs A/B, pulses mm_start, drains the result.
// Optional watchdog on mm_done is enabled with `define MATMUL_CTRL_TIMEOUT_EN.
module matmul_stream_ctrl #(
    parameter int S       = 32,
    parameter int W       = 2,
    parameter int H       = 2,
    parameter int C       = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [S-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [S-1:0]     out_data,
    output logic             out_last,
    output logic             mm_start,
    output logic [S*H*C-1:0] mm_a,
    output logic [S*C*W-1:0] mm_b,
    input  logic [S*H*W-1:0] mm_o,
    input  logic             mm_done,
    output logic             busy,
    output logic             timeout
);
    localparam int NA    = H * C;
    localparam int NB    = C * W;
    localparam int NO    = H * W;
    localparam int AW    = S * NA;
    localparam int BW    = S * NB;
    localparam int OW    = S * NO;
    localparam int NMAX  = (NA > NB) ? ((NA > NO) ? NA : NO) : ((NB > NO) ? NB : NO);
    localparam int CNT_W = $clog2(NMAX + 1);
    localparam int TMAX  = (TIMEOUT > 2) ? TIMEOUT : 2;
    localparam int GRD_W = $clog2(TMAX + 1);

    typedef enum logic [2:0] {LOAD_A, LOAD_B, START, WAIT, DRAIN} state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [GRD_W-1:0] grd, grd_d;
    logic [OW-1:0]    res, res_d;
    logic [AW-1:0]    a_d;
    logic [BW-1:0]    b_d;
    logic [S-1:0]     out_data_d;
    logic             in_ready_d, out_valid_d, out_last_d, mm_start_d, busy_d;
    logic             take_in, take_out, done_ok, expire;

    // Result index n = i*W + j maps to the core's column-major slot NO-1-(j*H+i).
    function automatic logic [S-1:0] pick_word(input logic [OW-1:0] r, input logic [CNT_W-1:0] n);
        pick_word = '0;
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++)
                if (n == CNT_W'(i * W + j))
                    pick_word = r[S*(NO-1-(j*H+i)) +: S];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD_A;
            cnt       <= '0;
            grd       <= '0;
            res       <= '0;
            mm_a      <= '0;
            mm_b      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            mm_start  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            grd       <= grd_d;
            res       <= res_d;
            mm_a      <= a_d;
            mm_b      <= b_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_last  <= out_last_d;
            out_data  <= out_data_d;
            mm_start  <= mm_start_d;
            busy      <= busy_d;
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        grd_d    = grd;
        res_d    = res;
        done_ok  = 1'b0;
        expire   = 1'b0;
        take_in  = in_valid && in_ready;
        take_out = out_valid && out_ready;
        case (state)
            LOAD_A: if (take_in) begin
                if (cnt == CNT_W'(NA - 1)) begin
                    state_d = LOAD_B;
                    cnt_d   = '0;
                end else cnt_d = cnt + CNT_W'(1);
            end
            LOAD_B: if (take_in) begin
                if (cnt == CNT_W'(NB - 1)) begin
                    state_d = START;
                    cnt_d   = '0;
                end else cnt_d = cnt + CNT_W'(1);
            end
            START: begin
                state_d = WAIT;
                grd_d   = '0;
            end
            WAIT: begin
                // The first two WAIT cycles may still see done from the previous operation.
                done_ok = mm_done && (grd >= GRD_W'(2));
`ifdef MATMUL_CTRL_TIMEOUT_EN
                expire  = !done_ok && (grd == GRD_W'(TIMEOUT - 1));
`endif
                if (done_ok) begin
                    res_d   = mm_o;
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else if (expire) begin
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
`ifdef MATMUL_CTRL_TIMEOUT_EN
                    grd_d = grd + GRD_W'(1);
`else
                    if (grd < GRD_W'(2)) grd_d = grd + GRD_W'(1);
`endif
                end
            end
            DRAIN: if (take_out) begin
                if (cnt == CNT_W'(NO - 1)) begin
                    state_d = LOAD_A;
                    cnt_d   = '0;
                end else cnt_d = cnt + CNT_W'(1);
            end
            default: state_d = LOAD_A;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_comb begin
        in_ready_d  = (state_d == LOAD_A) || (state_d == LOAD_B);
        mm_start_d  = (state_d == START);
        busy_d      = !((state_d == LOAD_A) && (cnt_d == '0));
        out_valid_d = (state_d == DRAIN);
        out_last_d  = (state_d == DRAIN) && (cnt_d == CNT_W'(NO - 1));
        out_data_d  = (state_d == DRAIN) ? pick_word(res_d, cnt_d) : '0;
        a_d         = mm_a;
        b_d         = mm_b;
        if (state == LOAD_A && take_in) a_d = (mm_a << S) | AW'(in_data);
        if (state == LOAD_B && take_in) b_d = (mm_b << S) | BW'(in_data);
    end

`ifdef MATMUL_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) timeout <= 1'b0;
        else if (expire) timeout <= 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// Bench for matmul_stream_ctrl: table of operations, stub matmul core, output scoreboard.
module tb_matmul_stream_ctrl;
    localparam int S = 32, W = 2, H = 2, C = 2, TO = 16;

    logic           clk = 1'b0, rst_n = 1'b0;
    logic           in_valid = 1'b0, in_ready;
    logic [S-1:0]   in_data = '0;
    logic           out_valid, out_ready = 1'b0, out_last;
    logic [S-1:0]   out_data;
    logic           mm_start, busy, timeout;
    logic [127:0]   mm_a, mm_b;
    logic [127:0]   mm_o = '0;
    logic           mm_done = 1'b0;

    matmul_stream_ctrl #(.S(S), .W(W), .H(H), .C(C), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_o(mm_o), .mm_done(mm_done),
        .busy(busy), .timeout(timeout));

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] a, b, o, e;
        bit           stale;
        int           stall_word;
        int           rst_word;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        last;
    } exp_t;

    int   n_tests = 0, n_fail = 0, n_words = 0, n_start = 0;
    exp_t exp_q[$];
    vec_t vecs[5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mm_start) n_start++;
            if (out_valid && out_ready) begin
                exp_t e;
                n_words++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL extra_word: got %0h, required no word", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_last", out_last, e.last);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("in_ready_timeout", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic load_and_start(input vec_t v);
        int t = 0;
        if (v.stale) begin
            mm_o    = {4{32'hDEADBEEF}};
            mm_done = 1'b1;
        end
        for (int k = 0; k < 4; k++) send_word(v.a[127-32*k -: 32]);
        check("busy_load_b", busy, 1'b1);
        for (int k = 0; k < 4; k++) send_word(v.b[127-32*k -: 32]);
        @(negedge clk);
        while (!mm_start && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("start_seen", mm_start, 1'b1);
        check("mm_a_pack", mm_a, v.a);
        check("mm_b_pack", mm_b, v.b);
        check("in_ready_start", in_ready, 1'b0);
        step();
        step();
        mm_done = 1'b0;
        mm_o    = v.o;
        step();
        check("no_early_capture", out_valid, 1'b0);
        check("in_ready_wait", in_ready, 1'b0);
    endtask

    task automatic drain(input vec_t v, input int base);
        int t = 0;
        out_ready = 1'b1;
        while (n_words - base < 4 && t < 100) begin
            if (v.rst_word >= 0 && n_words - base == v.rst_word) begin
                #1 rst_n = 1'b0;
                #1;
                check("rst_in_ready", in_ready, 1'b1);
                check("rst_out_valid", out_valid, 1'b0);
                check("rst_out_last", out_last, 1'b0);
                check("rst_out_data", out_data, 0);
                check("rst_busy", busy, 1'b0);
                check("rst_mm_a", mm_a, 0);
                exp_q.delete();
                out_ready = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                step();
                return;
            end
            if (v.stall_word >= 0 && n_words - base == v.stall_word) begin
                out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    step();
                    check("stall_valid", out_valid, 1'b1);
                    check("stall_data", out_data, v.e[127-32*v.stall_word -: 32]);
                end
                out_ready = 1'b1;
            end
            step();
            t++;
        end
        check("word_count", n_words - base, 4);
        check("back_to_idle_busy", busy, 1'b0);
        check("back_to_idle_ready", in_ready, 1'b1);
        step();
        step();
        check("no_extra_words", n_words - base, 4);
        check("queue_empty", exp_q.size(), 0);
    endtask

    task automatic run_op(input vec_t v);
        int base_w, base_s;
        base_s = n_start;
        load_and_start(v);
        for (int k = 0; k < 4; k++) exp_q.push_back('{d: v.e[127-32*k -: 32], last: (k == 3)});
        base_w  = n_words;
        mm_done = 1'b1;
        step();
        mm_done = 1'b0;
        check("start_pulses", n_start - base_s, 1);
        drain(v, base_w);
        check("timeout_flag", timeout, 1'b0);
    endtask

    initial begin
        vecs[0] = '{a: 128'h3F800000_40000000_40400000_40800000, b: 128'h3F800000_00000000_00000000_3F800000,
                    o: 128'h3F800000_40400000_40000000_40800000, e: 128'h3F800000_40000000_40400000_40800000,
                    stale: 1'b0, stall_word: -1, rst_word: -1};
        vecs[1] = '{a: 128'h40000000_3F800000_BF800000_41200000, b: 128'h11111111_22222222_33333333_44444444,
                    o: 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000, e: 128'hDDDD0003_BBBB0001_CCCC0002_AAAA0000,
                    stale: 1'b0, stall_word: -1, rst_word: -1};
        vecs[2] = '{a: 128'h0A0A0A0A_0B0B0B0B_0C0C0C0C_0D0D0D0D, b: 128'hCAFEF00D_12345678_9ABCDEF0_0F0F0F0F,
                    o: 128'h01010101_02020202_03030303_04040404, e: 128'h01010101_03030303_02020202_04040404,
                    stale: 1'b0, stall_word: 2, rst_word: -1};
        vecs[3] = '{a: 128'h00000001_00000002_00000003_00000004, b: 128'h00000004_00000003_00000002_00000001,
                    o: 128'h5A5A0000_5A5A0001_5A5A0002_5A5A0003, e: 128'h5A5A0000_5A5A0002_5A5A0001_5A5A0003,
                    stale: 1'b1, stall_word: -1, rst_word: -1};
        vecs[4] = vecs[1];
        vecs[4].rst_word = 1;

        #12;
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_last", out_last, 1'b0);
        check("reset_mm_start", mm_start, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_timeout", timeout, 1'b0);
        check("reset_mm_a", mm_a, 0);
        check("reset_mm_b", mm_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 5; v++) run_op(vecs[v]);
        run_op(vecs[0]);

`ifdef MATMUL_CTRL_TIMEOUT_EN
        begin
            int cyc = 0;
            int base_w;
            load_and_start(vecs[0]);
            // load_and_start returns in the 3rd WAIT cycle
            while (!timeout && cyc < 60) begin
                step();
                cyc++;
            end
            check("timeout_cycle", cyc + 3, TO + 1);
            check("timeout_drain_valid", out_valid, 1'b1);
            for (int k = 0; k < 4; k++) exp_q.push_back('{d: 32'h0, last: (k == 3)});
            base_w = n_words;
            vecs[0].stall_word = -1;
            vecs[0].rst_word = -1;
            out_ready = 1'b1;
            cyc = 0;
            while (n_words - base_w < 4 && cyc < 40) begin
                step();
                cyc++;
            end
            check("timeout_words", n_words - base_w, 4);
            check("timeout_sticky", timeout, 1'b1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1);
    end
endmodule
